// File: rtl/fma16_issue.sv
// ---------------------------------------------------------------------------
// fma16_issue
//
// Operand-issue and result-retire stage placed directly in front of the
// combinational fma16 datapath. Operations arrive over a valid/ready
// handshake and wait in a small FIFO. The head entry is decoded
// combinationally into the x/y/z/mul/add/negp/negz/roundmode controls that
// fma16 consumes. The fma16 result and flags are then captured into an
// output register, and sticky exception flags are accumulated.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready == !full)
//   in_op, in_x, in_y,  opcode, raw half-precision operands and rounding
//   in_z, in_rm         mode of the incoming operation
//   fma_x/y/z, fma_mul, operands and controls driven to fma16 from the
//   fma_add, fma_negp,  FIFO head (all zero while the FIFO is empty)
//   fma_negz, fma_rm
//   fma_result,         combinational result and flags returned by fma16,
//   fma_flags           flags ordered {invalid, overflow, underflow, inexact}
//   out_valid/out_ready downstream handshake for the output register
//   out_result,         registered result and its flags
//   out_flags
//   fflags, fflags_clr  sticky OR of retired flags and its clear
// ---------------------------------------------------------------------------
module fma16_issue #(
   parameter int DEPTH = 4,
   parameter int FLEN  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [FLEN-1:0] in_x,
   input  logic [FLEN-1:0] in_y,
   input  logic [FLEN-1:0] in_z,
   input  logic [1:0]      in_rm,
   output logic [FLEN-1:0] fma_x,
   output logic [FLEN-1:0] fma_y,
   output logic [FLEN-1:0] fma_z,
   output logic            fma_mul,
   output logic            fma_add,
   output logic            fma_negp,
   output logic            fma_negz,
   output logic [1:0]      fma_rm,
   input  logic [FLEN-1:0] fma_result,
   input  logic [3:0]      fma_flags,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [FLEN-1:0] out_result,
   output logic [3:0]      out_flags,
   output logic [3:0]      fflags,
   input  logic            fflags_clr
);

   localparam int              PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0]     FULL_COUNT = (PW+1)'(DEPTH);
   localparam logic [FLEN-1:0] ONE_VAL    = FLEN'(16'h3C00);
   localparam logic [FLEN-1:0] QNAN_VAL   = FLEN'(16'h7E00);
   localparam logic [3:0]      NV_FLAG    = 4'b1000;

   typedef enum logic [2:0] {
      OP_FMUL   = 3'b000,
      OP_FADD   = 3'b001,
      OP_FSUB   = 3'b010,
      OP_FMADD  = 3'b011,
      OP_FMSUB  = 3'b100,
      OP_FNMADD = 3'b101,
      OP_FNMSUB = 3'b110,
      OP_RSVD   = 3'b111
   } op_e;

   typedef struct packed {
      op_e             op;
      logic [FLEN-1:0] x;
      logic [FLEN-1:0] y;
      logic [FLEN-1:0] z;
      logic [1:0]      rm;
   } entry_t;

   entry_t          fifoMem [DEPTH];
   entry_t          head;
   logic [PW-1:0]   wrPtr_q, wrPtr_d;
   logic [PW-1:0]   rdPtr_q, rdPtr_d;
   logic [PW:0]     count_q, count_d;
   logic            outValid_q, outValid_d;
   logic [FLEN-1:0] outResult_q, outResult_d;
   logic [3:0]      outFlags_q, outFlags_d;
   logic [3:0]      fflags_q, fflags_d;
   logic            full, headValid, push, retire;
   logic [FLEN-1:0] newResult;
   logic [3:0]      newFlags;

   assign full       = (count_q == FULL_COUNT);
   assign headValid  = (count_q != '0);
   assign in_ready   = ~full;
   assign head       = fifoMem[rdPtr_q];
   assign push       = in_valid & ~full;
   assign retire     = headValid & (~outValid_q | out_ready);

   assign out_valid  = outValid_q;
   assign out_result = outResult_q;
   assign out_flags  = outFlags_q;
   assign fflags     = fflags_q;

   // Decode the FIFO head into fma16 controls. Add-only ops feed y through
   // the addend port and multiply x by 1.0; the reserved opcode is pushed
   // through as an FMADD and its result is replaced at retire time.
   always_comb begin
      fma_x    = '0;
      fma_y    = '0;
      fma_z    = '0;
      fma_mul  = 1'b0;
      fma_add  = 1'b0;
      fma_negp = 1'b0;
      fma_negz = 1'b0;
      fma_rm   = 2'b00;
      if (headValid) begin
         fma_x  = head.x;
         fma_rm = head.rm;
         case (head.op)
            OP_FMUL: begin
               fma_y   = head.y;
               fma_mul = 1'b1;
            end
            OP_FADD, OP_FSUB: begin
               fma_y    = ONE_VAL;
               fma_z    = head.y;
               fma_add  = 1'b1;
               fma_negz = (head.op == OP_FSUB);
            end
            default: begin
               fma_y    = head.y;
               fma_z    = head.z;
               fma_mul  = 1'b1;
               fma_add  = 1'b1;
               fma_negp = (head.op == OP_FNMADD) || (head.op == OP_FNMSUB);
               fma_negz = (head.op == OP_FMSUB) || (head.op == OP_FNMADD);
            end
         endcase
      end
   end

   // Next-state logic for the FIFO bookkeeping, the output register and the
   // sticky flags. A clear coinciding with a retire keeps only the new flags
   // so that the retiring operation is never lost.
   always_comb begin
      newResult   = (head.op == OP_RSVD) ? QNAN_VAL : fma_result;
      newFlags    = (head.op == OP_RSVD) ? NV_FLAG : fma_flags;
      wrPtr_d     = push ? wrPtr_q + 1'b1 : wrPtr_q;
      rdPtr_d     = retire ? rdPtr_q + 1'b1 : rdPtr_q;
      count_d     = count_q;
      case ({push, retire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      outValid_d  = outValid_q;
      outResult_d = outResult_q;
      outFlags_d  = outFlags_q;
      if (retire) begin
         outValid_d  = 1'b1;
         outResult_d = newResult;
         outFlags_d  = newFlags;
      end else if (out_ready) begin
         outValid_d  = 1'b0;
      end
      case ({fflags_clr, retire})
         2'b10:   fflags_d = 4'b0000;
         2'b01:   fflags_d = fflags_q | newFlags;
         2'b11:   fflags_d = newFlags;
         default: fflags_d = fflags_q;
      endcase
   end

   // State registers; reset wins over every other update in the same cycle
   // and discards anything queued or held in the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q     <= '0;
         rdPtr_q     <= '0;
         count_q     <= '0;
         outValid_q  <= 1'b0;
         outResult_q <= '0;
         outFlags_q  <= '0;
         fflags_q    <= '0;
      end else begin
         wrPtr_q     <= wrPtr_d;
         rdPtr_q     <= rdPtr_d;
         count_q     <= count_d;
         outValid_q  <= outValid_d;
         outResult_q <= outResult_d;
         outFlags_q  <= outFlags_d;
         fflags_q    <= fflags_d;
      end
   end

   // FIFO storage needs no reset; an entry is only read once the count says
   // it has been written.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         fifoMem[wrPtr_q] <= '{op: op_e'(in_op), x: in_x, y: in_y, z: in_z, rm: in_rm};
      end
   end

endmodule

// File: tb/tb_fma16_issue.sv
// ---------------------------------------------------------------------------
// tb_fma16_issue
//
// Self-checking bench for fma16_issue. The fma16 datapath is replaced by a
// small stand-in that returns true half-precision results for the directed
// operand sets used here and a deterministic mix of its inputs otherwise.
// ---------------------------------------------------------------------------
module tb_fma16_issue;

   localparam int DEPTH = 4;
   localparam int FLEN  = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      in_op;
   logic [FLEN-1:0] in_x, in_y, in_z;
   logic [1:0]      in_rm;
   logic [FLEN-1:0] fma_x, fma_y, fma_z;
   logic            fma_mul, fma_add, fma_negp, fma_negz;
   logic [1:0]      fma_rm;
   logic [FLEN-1:0] fma_result;
   logic [3:0]      fma_flags;
   logic            out_valid;
   logic            out_ready;
   logic [FLEN-1:0] out_result;
   logic [3:0]      out_flags;
   logic [3:0]      fflags;
   logic            fflags_clr;

   int checks   = 0;
   int failures = 0;

   // Scoreboard state for the free-running phases.
   bit          sbOn = 1'b0;
   logic [19:0] expQ[$];
   int          sbPops = 0;
   logic [3:0]  fflagsModel = 4'b0000;

   always #5 clk = ~clk;

   fma16_issue #(.DEPTH(DEPTH), .FLEN(FLEN)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_x(in_x), .in_y(in_y), .in_z(in_z), .in_rm(in_rm),
      .fma_x(fma_x), .fma_y(fma_y), .fma_z(fma_z),
      .fma_mul(fma_mul), .fma_add(fma_add), .fma_negp(fma_negp), .fma_negz(fma_negz),
      .fma_rm(fma_rm), .fma_result(fma_result), .fma_flags(fma_flags),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags),
      .fflags(fflags), .fflags_clr(fflags_clr)
   );

   // Stand-in for fma16: {result, flags} from the decoded controls.
   function automatic logic [19:0] fmaStub(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z, input logic [3:0] ctl);
      logic [15:0] r;
      if      (x == 16'h4000 && y == 16'h4200 && z == 16'h0000 && ctl == 4'b1000) return {16'h4600, 4'b0000};
      else if (x == 16'h4000 && y == 16'h3C00 && z == 16'h4200 && ctl == 4'b0100) return {16'h4500, 4'b0000};
      else if (x == 16'h4000 && y == 16'h3C00 && z == 16'h4200 && ctl == 4'b0101) return {16'hBC00, 4'b0000};
      else if (x == 16'h4000 && y == 16'h4200 && z == 16'h3C00 && ctl == 4'b1100) return {16'h4700, 4'b0000};
      else if (x == 16'h4000 && y == 16'h4200 && z == 16'h3C00 && ctl == 4'b1101) return {16'h4500, 4'b0000};
      else if (x == 16'h4000 && y == 16'h4200 && z == 16'h3C00 && ctl == 4'b1111) return {16'hC700, 4'b0000};
      else if (x == 16'h4000 && y == 16'h4200 && z == 16'h3C00 && ctl == 4'b1110) return {16'hC500, 4'b0000};
      else if (x == 16'h7C00 && y == 16'h0000 && z == 16'h0000 && ctl == 4'b1000) return {16'h7E00, 4'b1000};
      r = x ^ {y[10:0], y[15:11]} ^ {z[4:0], z[15:5]} ^ {ctl, 12'h2A5};
      return {r, r[3:0] ^ r[15:12]};
   endfunction

   always_comb begin
      {fma_result, fma_flags} = fmaStub(fma_x, fma_y, fma_z, {fma_mul, fma_add, fma_negp, fma_negz});
   end

   // Independent model of the issue stage: opcode decode, stub, override.
   function automatic logic [19:0] refModel(input logic [2:0] op, input logic [15:0] x,
                                            input logic [15:0] y, input logic [15:0] z);
      logic [15:0] dy, dz;
      logic [3:0]  ctl;
      case (op)
         3'b000:  begin dy = y;       dz = 16'h0000; ctl = 4'b1000; end
         3'b001:  begin dy = 16'h3C00; dz = y;      ctl = 4'b0100; end
         3'b010:  begin dy = 16'h3C00; dz = y;      ctl = 4'b0101; end
         3'b011:  begin dy = y;       dz = z;       ctl = 4'b1100; end
         3'b100:  begin dy = y;       dz = z;       ctl = 4'b1101; end
         3'b101:  begin dy = y;       dz = z;       ctl = 4'b1111; end
         3'b110:  begin dy = y;       dz = z;       ctl = 4'b1110; end
         default: begin dy = y;       dz = z;       ctl = 4'b1100; end
      endcase
      if (op == 3'b111) return {16'h7E00, 4'b1000};
      return fmaStub(x, dy, dz, ctl);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [15:0] x,
                                input logic [15:0] y, input logic [15:0] z, input logic [1:0] rm);
      in_valid = valid;
      in_op    = op;
      in_x     = x;
      in_y     = y;
      in_z     = z;
      in_rm    = rm;
   endtask

   // Advance one clock. Handshakes are evaluated just before the edge with
   // the inputs already set, then outputs settle #1 after the edge.
   task automatic tick();
      logic [19:0] e;
      if (sbOn && out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL sbUnexpected: got result 0x%0h with nothing expected", out_result);
         end else begin
            e = expQ.pop_front();
            checkOutput("sbResult", out_result, e[19:4]);
            checkOutput("sbFlags", out_flags, e[3:0]);
            fflagsModel = fflagsModel | e[3:0];
            sbPops++;
         end
      end
      if (sbOn && in_valid && in_ready) expQ.push_back(refModel(in_op, in_x, in_y, in_z));
      @(posedge clk);
      #1;
   endtask

   task automatic checkEmptyFma(input string name);
      checkOutput(name, {fma_x, fma_y, fma_z, fma_mul, fma_add, fma_negp, fma_negz, fma_rm}, 64'h0);
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [15:0] x, y, z;
      logic [1:0]  rm;
      logic [15:0] ex, ey, ez;
      logic [3:0]  ectl;
      logic [15:0] eres;
      logic [3:0]  eflags;
      logic [3:0]  efflags;
   } vec_t;

   vec_t vecs[9];

   // Watchdog so the bench always ends even if the DUT wedges.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int i, cyc, pushed;
      bit acc;
      logic [2:0]  bpOp[6];
      logic [15:0] bpX[6];

      vecs[0] = '{3'b000, 16'h4000, 16'h4200, 16'h1234, 2'b00, 16'h4000, 16'h4200, 16'h0000, 4'b1000, 16'h4600, 4'b0000, 4'b0000};
      vecs[1] = '{3'b001, 16'h4000, 16'h4200, 16'h5555, 2'b10, 16'h4000, 16'h3C00, 16'h4200, 4'b0100, 16'h4500, 4'b0000, 4'b0000};
      vecs[2] = '{3'b010, 16'h4000, 16'h4200, 16'h0000, 2'b11, 16'h4000, 16'h3C00, 16'h4200, 4'b0101, 16'hBC00, 4'b0000, 4'b0000};
      vecs[3] = '{3'b011, 16'h4000, 16'h4200, 16'h3C00, 2'b01, 16'h4000, 16'h4200, 16'h3C00, 4'b1100, 16'h4700, 4'b0000, 4'b0000};
      vecs[4] = '{3'b100, 16'h4000, 16'h4200, 16'h3C00, 2'b00, 16'h4000, 16'h4200, 16'h3C00, 4'b1101, 16'h4500, 4'b0000, 4'b0000};
      vecs[5] = '{3'b101, 16'h4000, 16'h4200, 16'h3C00, 2'b10, 16'h4000, 16'h4200, 16'h3C00, 4'b1111, 16'hC700, 4'b0000, 4'b0000};
      vecs[6] = '{3'b110, 16'h4000, 16'h4200, 16'h3C00, 2'b01, 16'h4000, 16'h4200, 16'h3C00, 4'b1110, 16'hC500, 4'b0000, 4'b0000};
      vecs[7] = '{3'b111, 16'h4000, 16'h4200, 16'h3C00, 2'b11, 16'h4000, 16'h4200, 16'h3C00, 4'b1100, 16'h7E00, 4'b1000, 4'b1000};
      vecs[8] = '{3'b000, 16'h7C00, 16'h0000, 16'h0000, 2'b00, 16'h7C00, 16'h0000, 16'h0000, 4'b1000, 16'h7E00, 4'b1000, 4'b1000};

      // Reset state.
      reset = 1'b1;
      out_ready = 1'b1;
      fflags_clr = 1'b0;
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 2'b00);
      tick();
      tick();
      checkOutput("rstInReady", in_ready, 1);
      checkOutput("rstOutValid", out_valid, 0);
      checkOutput("rstOutResult", out_result, 0);
      checkOutput("rstOutFlags", out_flags, 0);
      checkOutput("rstFflags", fflags, 0);
      checkEmptyFma("rstFma");
      reset = 1'b0;
      tick();

      // Table-driven decode and retire checks, one op at a time.
      foreach (vecs[k]) begin
         applyStimulus(1'b1, vecs[k].op, vecs[k].x, vecs[k].y, vecs[k].z, vecs[k].rm);
         tick();
         applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 2'b00);
         checkOutput($sformatf("vec%0d_fmaX", k), fma_x, vecs[k].ex);
         checkOutput($sformatf("vec%0d_fmaY", k), fma_y, vecs[k].ey);
         checkOutput($sformatf("vec%0d_fmaZ", k), fma_z, vecs[k].ez);
         checkOutput($sformatf("vec%0d_fmaCtl", k), {fma_mul, fma_add, fma_negp, fma_negz}, vecs[k].ectl);
         checkOutput($sformatf("vec%0d_fmaRm", k), fma_rm, vecs[k].rm);
         checkOutput($sformatf("vec%0d_notYetValid", k), out_valid, 0);
         tick();
         checkOutput($sformatf("vec%0d_outValid", k), out_valid, 1);
         checkOutput($sformatf("vec%0d_outResult", k), out_result, vecs[k].eres);
         checkOutput($sformatf("vec%0d_outFlags", k), out_flags, vecs[k].eflags);
         checkOutput($sformatf("vec%0d_fflags", k), fflags, vecs[k].efflags);
         tick();
         checkOutput($sformatf("vec%0d_drained", k), out_valid, 0);
      end

      // Back-to-back FADD then FSUB retire on consecutive cycles.
      applyStimulus(1'b1, 3'b001, 16'h4000, 16'h4200, 16'h0000, 2'b00);
      tick();
      applyStimulus(1'b1, 3'b010, 16'h4000, 16'h4200, 16'h0000, 2'b00);
      tick();
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 2'b00);
      checkOutput("b2bFirstValid", out_valid, 1);
      checkOutput("b2bFirstResult", out_result, 16'h4500);
      tick();
      checkOutput("b2bSecondValid", out_valid, 1);
      checkOutput("b2bSecondResult", out_result, 16'hBC00);
      checkEmptyFma("emptyFma");
      tick();
      checkOutput("b2bDrained", out_valid, 0);

      // Clear coinciding with a clean retire, then with a flagged retire,
      // then a clear on its own.
      applyStimulus(1'b1, 3'b011, 16'h4000, 16'h4200, 16'h3C00, 2'b01);
      tick();
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 2'b00);
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      checkOutput("clrRetireFflags", fflags, 4'b0000);
      checkOutput("clrRetireResult", out_result, 16'h4700);
      applyStimulus(1'b1, 3'b000, 16'h7C00, 16'h0000, 16'h0000, 2'b00);
      tick();
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 2'b00);
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      checkOutput("clrRetireNewFlags", fflags, 4'b1000);
      checkOutput("nvOutFlags", out_flags, 4'b1000);
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      checkOutput("clrAlone", fflags, 4'b0000);

      // Mid-stream reset with entries queued and a flagged result held.
      out_ready = 1'b0;
      applyStimulus(1'b1, 3'b000, 16'h7C00, 16'h0000, 16'h0000, 2'b00);
      tick();
      applyStimulus(1'b1, 3'b001, 16'h4000, 16'h4200, 16'h0000, 2'b00);
      tick();
      applyStimulus(1'b1, 3'b010, 16'h4000, 16'h4200, 16'h0000, 2'b00);
      tick();
      checkOutput("preRstValid", out_valid, 1);
      checkOutput("preRstFflags", fflags, 4'b1000);
      applyStimulus(1'b1, 3'b011, 16'h4000, 16'h4200, 16'h3C00, 2'b00);
      fflags_clr = 1'b1;
      out_ready = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      fflags_clr = 1'b0;
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 2'b00);
      checkOutput("midRstOutValid", out_valid, 0);
      checkOutput("midRstFflags", fflags, 0);
      checkOutput("midRstInReady", in_ready, 1);
      checkOutput("midRstOutResult", out_result, 0);
      checkEmptyFma("midRstFma");
      tick();
      checkEmptyFma("postRstStillEmpty");
      checkOutput("postRstNoOutput", out_valid, 0);
      applyStimulus(1'b1, 3'b011, 16'h4000, 16'h4200, 16'h3C00, 2'b01);
      tick();
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 2'b00);
      tick();
      checkOutput("postRstResult", out_result, 16'h4700);
      tick();

      // Backpressure: six ops with out_ready low, one held at the boundary.
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      sbOn = 1'b1;
      fflagsModel = 4'b0000;
      sbPops = 0;
      bpOp[0] = 3'b011; bpOp[1] = 3'b001; bpOp[2] = 3'b111;
      bpOp[3] = 3'b000; bpOp[4] = 3'b110; bpOp[5] = 3'b010;
      for (int k = 0; k < 6; k++) bpX[k] = 16'h1000 + 16'(k * 16'h0111);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b1, bpOp[k], bpX[k], 16'h2345 + 16'(k), 16'h0F0F, 2'(k));
         checkOutput($sformatf("bpReady%0d", k), in_ready, 1);
         tick();
      end
      applyStimulus(1'b1, bpOp[5], bpX[5], 16'h2345 + 16'd5, 16'h0F0F, 2'd1);
      checkOutput("bpFullNotReady", in_ready, 0);
      tick();
      tick();
      checkOutput("bpStillNotReady", in_ready, 0);
      checkOutput("bpHeldValid", out_valid, 1);
      checkOutput("bpHeldResult", out_result, refModel(bpOp[0], bpX[0], 16'h2345, 16'h0F0F) >> 4);
      checkOutput("bpQueued", expQ.size(), 5);
      out_ready = 1'b1;
      acc = 1'b0;
      cyc = 0;
      while (cyc < 40 && !(acc && expQ.size() == 0 && !out_valid)) begin
         if (!acc && in_ready) acc = 1'b1;
         tick();
         if (acc) applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 2'b00);
         cyc++;
      end
      checkOutput("bpTimeout", cyc < 40, 1);
      checkOutput("bpPops", sbPops, 6);
      checkOutput("bpFflags", fflags, fflagsModel);

      // Wrap-around: 20 random ops with random downstream stalls.
      sbPops = 0;
      pushed = 0;
      cyc = 0;
      fflagsModel = fflags;
      while (pushed < 20 && cyc < 400) begin
         applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                       16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
         out_ready = 1'($urandom_range(0, 1));
         if (in_valid && in_ready) pushed++;
         tick();
         cyc++;
      end
      applyStimulus(1'b0, 3'b000, 16'h0, 16'h0, 16'h0, 2'b00);
      out_ready = 1'b1;
      i = 0;
      while (i < 40 && (expQ.size() != 0 || out_valid)) begin
         tick();
         i++;
      end
      checkOutput("wrapPushTimeout", pushed, 20);
      checkOutput("wrapDrainTimeout", i < 40, 1);
      checkOutput("wrapPops", sbPops, 20);
      checkOutput("wrapFflags", fflags, fflagsModel);
      checkEmptyFma("wrapEmptyFma");
      sbOn = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fma16_issue.md
# fma16_issue

Operand-issue and result-retire stage that sits directly upstream of `fma16` and owns its output register. It accepts floating-point operations over a valid/ready handshake and buffers them in a small FIFO. It decodes each opcode into the `x`/`y`/`z`/`mul`/`add`/`negp`/`negz`/`roundmode` controls that `fma16` consumes, registers the combinational `fma16` result and flags into an output stage, and accumulates sticky exception flags (fflags).

## Interface
- `DEPTH`, 4 — operand FIFO entries; must be a power of two, ≥2.
- `FLEN`, `NE`, `NF` — taken from `fma.vh`; `FLEN`=16.

- `clk`  in  1  — clock; all state updates on its rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `in_valid`  in  1  — upstream presents an operation.
- `in_ready`  out  1  — FIFO can accept; equals `!full`.
- `in_op`  in  3  — opcode (see Operation).
- `in_x`, `in_y`, `in_z`  in  FLEN each  — raw half-precision operands.
- `in_rm`  in  2  — rounding mode, passed through unchanged.
- `fma_x`, `fma_y`, `fma_z`  out  FLEN each  — operands to `fma16`.
- `fma_mul`, `fma_add`, `fma_negp`, `fma_negz`  out  1 each  — controls to `fma16`.
- `fma_rm`  out  2  — to `fma16` `roundmode`.
- `fma_result`  in  FLEN  — from `fma16`.
- `fma_flags`  in  4  — from `fma16`, ordered {invalid, overflow, underflow, inexact}.
- `out_valid`  out  1  — retired result held in the output register.
- `out_ready`  in  1  — downstream accepts the result.
- `out_result`  out  FLEN  — registered result.
- `out_flags`  out  4  — registered flags for that result.
- `fflags`  out  4  — sticky OR of all retired `out_flags`.
- `fflags_clr`  in  1  — clears `fflags`.

## Operation
- FIFO stores {op, x, y, z, rm}. Push when `in_valid & in_ready`. The head entry drives decode combinationally.
- Decode of the head entry (h = head):
  - 000 FMUL: x=h.x, y=h.y, z=0x0000, mul=1, add=0.
  - 001 FADD: x=h.x, y=0x3C00, z=h.y, mul=0, add=1.
  - 010 FSUB: as FADD, plus negz=1.
  - 011 FMADD: x,y,z from h, mul=1, add=1.
  - 100 FMSUB: as FMADD, plus negz=1.
  - 101 FNMADD: as FMADD, plus negp=1, negz=1.
  - 110 FNMSUB: as FMADD, plus negp=1.
  - All unlisted negp/negz are 0.
  - 111 reserved: decoded as FMADD, but retire overrides the result with 0x7E00 and the flags with 4'b1000.
- When the FIFO is empty, all `fma_*` outputs are 0.
- Retire condition: `head_valid & (!out_valid | out_ready)`. On retire:
  - capture `fma_result`/`fma_flags` (or the reserved override) into `out_result`/`out_flags`;
  - set `out_valid`=1;
  - pop the FIFO.
- When `out_valid & out_ready` occurs without a retire, `out_valid` goes to 0. `out_result` and `out_flags` hold their last value.
- fflags update:
  - `fflags_clr` alone: `fflags` ← 0.
  - Retire alone: `fflags` ← `fflags | new_flags`.
  - Both in the same cycle: `fflags` ← `new_flags`.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits. full = (count==DEPTH); empty = (count==0).
- Simultaneous push and pop with the FIFO not full: count unchanged. When the FIFO is full, `in_ready`=0; there is no same-cycle pass-through.

## Timing
- Reset values:
  - count, pointers = 0;
  - `out_valid`=0, `out_result`=0, `out_flags`=0, `fflags`=0;
  - `in_ready`=1;
  - `fma_*`=0.
- Reset has priority over push, retire and `fflags_clr` in the same cycle. Reset asserted mid-stream discards all FIFO entries and the output register.
- Latency: push in cycle N → head (and `fma_*` driven) in cycle N+1 → `out_valid` in cycle N+2.
- Throughput is 1 op/cycle while `out_ready`=1.
- Stall: with `out_ready`=0, `out_valid` stays high and `out_result` is stable. After `DEPTH` more pushes, `in_ready` drops in the cycle following the fill.
- `fma16` is purely combinational between `fma_*` and `fma_result`. No extra cycle is inserted.

## Test plan
- **FMADD:** bench instantiates a real `fma16`. Push op=011, x=0x4000, y=0x4200, z=0x3C00, rm=01 → two cycles later `out_valid`=1, `out_result`=0x4700, `out_flags`=0000.
- **FADD/FSUB and empty outputs:** push FADD x=0x4000, y=0x4200 → result 0x4500. Next cycle push FSUB with the same operands → result 0xBC00. Results must appear on consecutive cycles. With the FIFO empty, `fma_*`=0.
- **Backpressure and overflow:** hold `out_ready`=0 and push 6 ops with DEPTH=4:
  - the first op retires into the output register;
  - 4 more fill the FIFO;
  - `in_ready`=0 and the 6th op is held.
  - Release `out_ready`: all 6 results emerge in order, with no loss or duplicate.
- **Flags:** push FMUL x=0x7C00, y=0x0000 → `out_flags`=1000 and `fflags`=1000. Assert `fflags_clr` in the same cycle as the next retire, whose flags are 0000 → `fflags`=0000.
- **Reserved opcode and reset:**
  - op=111 → `out_result`=0x7E00, `out_flags`=1000.
  - Assert `reset` with 3 entries queued → next cycle count=0, `out_valid`=0, `fflags`=0, `in_ready`=1.
- **Wrap-around:** 20 random ops pushed with random `out_ready` → results match a reference model in order; the pointers wrap at least 4 times.
